// File: rtl/count_pkg.sv
// Shared defaults and the load-clamp helper for the modulo-MOD down counter.
package count_pkg;

  localparam int unsigned N_DEF   = 3;
  localparam int unsigned MOD_DEF = 6;

  // Out-of-range load values saturate to the top of the count range.
  function automatic int unsigned sat_load(input int unsigned c, input int unsigned modv);
    return (c >= modv) ? modv - 1 : c;
  endfunction

endpackage

// File: rtl/downcount_cell.sv
// One bit slice of the borrow-chain down counter: toggles on borrow-in,
// or takes the load/wrap bit when select is high.
module downcount_cell (
  input  logic clk,
  input  logic rst,
  input  logic bin,
  input  logic sel,
  input  logic d,
  output logic q,
  output logic bout
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= 1'b0;
    else if (sel) q <= d;
    else if (bin) q <= ~q;
  end

  // Borrow ripples on only while this bit is already 0.
  assign bout = bin & ~q;

endmodule

// File: rtl/countmodn_down_sinc.sv
// Modulo-MOD down counter with parallel load and combinational borrow-out,
// built from a chain of N downcount_cell slices.
module countmodn_down_sinc
  import count_pkg::*;
#(
  parameter int unsigned N   = N_DEF,
  parameter int unsigned MOD = MOD_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         En,
  input  logic         Ld,
  input  logic [N-1:0] C,
  output logic [N-1:0] Q,
  output logic         Bo
);

  generate
    if (MOD < 2 || 64'(MOD) > (64'(1) << N)) begin : g_bad_mod
      $error("countmodn_down_sinc: MOD must satisfy 2 <= MOD <= 2**N");
    end
  endgenerate

  localparam logic [N-1:0] WRAP_VAL = N'(MOD - 1);

  logic [N:0]   borrow;
  logic [N-1:0] load_val;
  logic [N-1:0] sel_val;
  logic         sel;

  // The chain end is En & (Q == 0): exactly the wrap condition and the borrow-out.
  assign borrow[0] = En;
  assign Bo        = borrow[N];
  assign sel       = Ld | borrow[N];
  assign load_val  = N'(sat_load(32'(C), MOD));
  assign sel_val   = Ld ? load_val : WRAP_VAL;

  for (genvar i = 0; i < N; i++) begin : g_cell
    downcount_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .bin  (borrow[i]),
      .sel  (sel),
      .d    (sel_val[i]),
      .q    (Q[i]),
      .bout (borrow[i+1])
    );
  end

endmodule

// File: tb/tb_countmodn_down_sinc.sv
// Self-checking bench for countmodn_down_sinc: vector table, async reset,
// and a two-digit cascade.
module tb_countmodn_down_sinc;

  logic       clk;
  logic       rst;
  logic       En;
  logic       Ld;
  logic [2:0] C;
  logic [2:0] Q;
  logic       Bo;

  logic       cu_en;
  logic [2:0] cu_c;
  logic [2:0] cu_q;
  logic       cu_bo;
  logic [3:0] ct_c;
  logic [3:0] ct_q;
  logic       ct_bo;
  logic       c_ld;

  int passed = 0;
  int total  = 0;

  logic [2:0] exp_q[$];

  typedef struct {
    string      name;
    logic       ld;
    logic       en;
    logic [2:0] c;
    logic [2:0] q;
    logic       bo;
  } vec_t;

  vec_t vecs[$];

  countmodn_down_sinc #(.N(3), .MOD(6)) dut (
    .clk(clk), .rst(rst), .En(En), .Ld(Ld), .C(C), .Q(Q), .Bo(Bo)
  );

  countmodn_down_sinc #(.N(3), .MOD(6)) u_units (
    .clk(clk), .rst(rst), .En(cu_en), .Ld(c_ld), .C(cu_c), .Q(cu_q), .Bo(cu_bo)
  );

  countmodn_down_sinc #(.N(4), .MOD(10)) u_tens (
    .clk(clk), .rst(rst), .En(cu_bo), .Ld(c_ld), .C(ct_c), .Q(ct_q), .Bo(ct_bo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
  endtask

  // Drive on the falling edge, check Bo before the rising edge, Q after it.
  task automatic step(input vec_t v);
    logic [2:0] e;
    @(negedge clk);
    Ld = v.ld; En = v.en; C = v.c;
    #1;
    check({v.name, " Bo"}, int'(Bo), int'(v.bo));
    exp_q.push_back(v.q);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) check({v.name, " Q scoreboard empty"}, 0, 1);
    else begin
      e = exp_q.pop_front();
      check({v.name, " Q"}, int'(Q), int'(e));
    end
  endtask

  initial begin
    // full cycle from 0
    vecs.push_back('{"cyc0", 1'b0, 1'b1, 3'd0, 3'd5, 1'b1});
    vecs.push_back('{"cyc1", 1'b0, 1'b1, 3'd0, 3'd4, 1'b0});
    vecs.push_back('{"cyc2", 1'b0, 1'b1, 3'd0, 3'd3, 1'b0});
    vecs.push_back('{"cyc3", 1'b0, 1'b1, 3'd0, 3'd2, 1'b0});
    vecs.push_back('{"cyc4", 1'b0, 1'b1, 3'd0, 3'd1, 1'b0});
    vecs.push_back('{"cyc5", 1'b0, 1'b1, 3'd0, 3'd0, 1'b0});
    vecs.push_back('{"cyc6", 1'b0, 1'b1, 3'd0, 3'd5, 1'b1});
    // down to 2, then load beats count
    vecs.push_back('{"to4", 1'b0, 1'b1, 3'd0, 3'd4, 1'b0});
    vecs.push_back('{"to3", 1'b0, 1'b1, 3'd0, 3'd3, 1'b0});
    vecs.push_back('{"to2", 1'b0, 1'b1, 3'd0, 3'd2, 1'b0});
    vecs.push_back('{"ld_prio", 1'b1, 1'b1, 3'd4, 3'd4, 1'b0});
    vecs.push_back('{"after_ld", 1'b0, 1'b1, 3'd0, 3'd3, 1'b0});
    // saturating loads
    vecs.push_back('{"sat7", 1'b1, 1'b0, 3'd7, 3'd5, 1'b0});
    vecs.push_back('{"sat6", 1'b1, 1'b0, 3'd6, 3'd5, 1'b0});
    vecs.push_back('{"ld3", 1'b1, 1'b0, 3'd3, 3'd3, 1'b0});
    for (int i = 0; i < 10; i++)
      vecs.push_back('{$sformatf("hold%0d", i), 1'b0, 1'b0, 3'd0, 3'd3, 1'b0});
    vecs.push_back('{"ld0", 1'b1, 1'b0, 3'd0, 3'd0, 1'b0});
    vecs.push_back('{"hold_zero", 1'b0, 1'b0, 3'd0, 3'd0, 1'b0});
    vecs.push_back('{"ld_over_wrap", 1'b1, 1'b1, 3'd2, 3'd2, 1'b1});
    vecs.push_back('{"ld_max", 1'b1, 1'b0, 3'd5, 3'd5, 1'b0});

    rst = 1'b1; En = 1'b0; Ld = 1'b0; C = '0;
    cu_en = 1'b0; cu_c = '0; ct_c = '0; c_ld = 1'b0;
    #12;
    check("reset Q", int'(Q), 0);
    check("reset Bo en0", int'(Bo), 0);
    En = 1'b1;
    #1;
    check("reset Bo en1", int'(Bo), 1);
    En = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) step(vecs[i]);

    // async reset between edges, mid-count
    step('{"ld_to3", 1'b1, 1'b0, 3'd3, 3'd3, 1'b0});
    @(negedge clk);
    Ld = 1'b0; En = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("async Q", int'(Q), 0);
    check("async Bo", int'(Bo), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst Q", int'(Q), 5);

    // cascade: units MOD=6 borrow drives tens MOD=10 enable
    @(negedge clk);
    En = 1'b0;
    rst = 1'b1;
    #1;
    check("casc rst units", int'(cu_q), 0);
    check("casc rst tens", int'(ct_q), 0);
    rst = 1'b0;
    @(negedge clk);
    cu_en = 1'b1;
    #1;
    check("casc tens Bo", int'(ct_bo), 1);
    @(posedge clk);
    #1;
    check("casc 95 tens", int'(ct_q), 9);
    check("casc 95 units", int'(cu_q), 5);
    for (int k = 1; k <= 3; k++) begin
      for (int j = 0; j < 5; j++) begin
        @(posedge clk);
        #1;
        check($sformatf("casc mid%0d_%0d tens", k, j), int'(ct_q), 10 - k);
      end
      @(posedge clk);
      #1;
      check($sformatf("casc wrap%0d tens", k), int'(ct_q), 9 - k);
      check($sformatf("casc wrap%0d units", k), int'(cu_q), 5);
    end
    cu_en = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
